fir_tcdm_reader: RTL and testbench

//  TCDM initiator that fetches a strided sequence of 32-bit words and emits them on a valid/ready stream.
//  It drives the req/gnt/r_valid TCDM master port on the FIR accelerator side.
//  The dummy TCDM memory in the FIR bench is the responder on the other end of that port.
//  It feeds FIR input samples and coefficients into the datapath.

---
 rtl/fir_tcdm_reader_pkg.sv | 25 ++
 rtl/fir_tcdm_reader_fifo.sv | 65 ++++++
 rtl/fir_tcdm_reader.sv | 150 +++++++++++++++
 tb/tb_fir_tcdm_reader.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_tcdm_reader_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fir_package: shared types for the FIR TCDM stream reader               |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package fir_package;

  localparam int unsigned FIR_ADDR_W      = 32;
  localparam int unsigned FIR_LEN_W       = 16;
  localparam logic [3:0]  FIR_TCDM_BE_ALL = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } fir_tcdm_reader_state_e;

  typedef struct packed {
    logic [FIR_ADDR_W-1:0] base;
    logic [FIR_LEN_W-1:0]  len;
    logic [FIR_ADDR_W-1:0] stride;
  } fir_tcdm_reader_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/fir_tcdm_reader_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fir_tcdm_reader_fifo: response buffer with occupancy count for credits |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module fir_tcdm_reader_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic                    push_i,
  input  logic [DATA_WIDTH-1:0]   push_data_i,
  input  logic                    pop_i,
  output logic [DATA_WIDTH-1:0]   pop_data_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  w_push;
  logic                  w_pop;

  assign empty_o    = (r_count == '0);
  assign full_o     = (r_count == c_depth);
  assign count_o    = r_count;
  assign pop_data_o = r_mem[r_rd_ptr];

  // A pop frees the slot a same-cycle push needs, so push at full is legal with pop.
  assign w_pop  = pop_i && !empty_o;
  assign w_push = push_i && !flush_i && (!full_o || w_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_mem    <= '{default: '0};
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_data_i;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fir_tcdm_reader.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fir_tcdm_reader: strided TCDM read initiator feeding a valid/ready     |
// | stream. Rev 1.0                                                       |
// +-----------------------------------------------------------------------+
module fir_tcdm_reader
  import fir_package::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic [ADDR_WIDTH-1:0] stride_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  tcdm_req_o,
  input  logic                  tcdm_gnt_i,
  output logic [ADDR_WIDTH-1:0] tcdm_add_o,
  output logic                  tcdm_wen_o,
  output logic [3:0]            tcdm_be_o,
  output logic [DATA_WIDTH-1:0] tcdm_data_o,
  input  logic [DATA_WIDTH-1:0] tcdm_r_data_i,
  input  logic                  tcdm_r_valid_i,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  input  logic                  out_ready_i
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] c_depth = (CNT_W+1)'(FIFO_DEPTH);

  fir_tcdm_reader_state_e r_state;
  fir_tcdm_reader_state_e w_state_next;
  fir_tcdm_reader_ctrl_t  w_ctrl;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_stride;
  logic [LEN_WIDTH-1:0]  r_remaining;
  logic [CNT_W-1:0]      r_outstanding;
  logic [CNT_W-1:0]      r_discard;
  logic                  r_zero_done;

  logic [CNT_W-1:0]      w_fifo_count;
  logic [CNT_W:0]        w_inflight;
  logic                  w_fifo_empty;
  logic                  w_fifo_full;
  logic                  w_credit;
  logic                  w_gnt;
  logic                  w_rsp;
  logic                  w_drop;
  logic                  w_pop;
  logic                  w_last;
  logic                  w_start;

  assign w_ctrl = '{base: base_addr_i, len: len_i, stride: stride_i};

  assign w_inflight = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
  assign w_credit   = !w_fifo_full && (w_inflight < c_depth);

  assign tcdm_req_o  = (r_state == REQ) && w_credit && !clear_i;
  assign tcdm_add_o  = r_addr;
  assign tcdm_wen_o  = 1'b1;
  assign tcdm_be_o   = FIR_TCDM_BE_ALL;
  assign tcdm_data_o = '0;

  // Responses with nothing outstanding (e.g. after a reset) are ignored.
  assign w_gnt  = tcdm_req_o && tcdm_gnt_i;
  assign w_drop = tcdm_r_valid_i && (r_discard != '0);
  assign w_rsp  = tcdm_r_valid_i && (r_discard == '0) && (r_outstanding != '0);

  assign out_valid_o = !w_fifo_empty;
  assign w_pop       = out_valid_o && out_ready_i;
  assign w_last      = (r_state == DRAIN) && w_pop && (r_outstanding == '0)
                       && (w_fifo_count == CNT_W'(1));
  assign w_start     = (r_state == IDLE) && start_i && !clear_i && (r_discard == '0);

  assign busy_o = (r_state != IDLE);
  assign done_o = w_last || r_zero_done;

  always_comb begin
    w_state_next = r_state;
    if (clear_i) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_start && (len_i != '0)) w_state_next = REQ;
        REQ:     if (w_gnt && (r_remaining == LEN_WIDTH'(1))) w_state_next = DRAIN;
        DRAIN:   if (w_last) w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      r_stride      <= '0;
      r_remaining   <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_zero_done   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_zero_done <= w_start && (len_i == '0);
      if (clear_i) begin
        // A response landing in the clear cycle is flushed here, so it is not owed to discard.
        r_outstanding <= '0;
        r_discard     <= r_discard - CNT_W'(w_drop) + r_outstanding - CNT_W'(w_rsp);
        r_remaining   <= '0;
      end else begin
        r_outstanding <= r_outstanding + CNT_W'(w_gnt) - CNT_W'(w_rsp);
        r_discard     <= r_discard - CNT_W'(w_drop);
        if (w_start) begin
          r_addr      <= w_ctrl.base;
          r_remaining <= w_ctrl.len;
          r_stride    <= w_ctrl.stride;
        end else if (w_gnt) begin
          r_addr      <= r_addr + r_stride;
          r_remaining <= r_remaining - LEN_WIDTH'(1);
        end
      end
    end
  end

  fir_tcdm_reader_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (clear_i),
    .push_i      (w_rsp),
    .push_data_i (tcdm_r_data_i),
    .pop_i       (w_pop),
    .pop_data_o  (out_data_o),
    .full_o      (w_fifo_full),
    .empty_o     (w_fifo_empty),
    .count_o     (w_fifo_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_fir_tcdm_reader.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_fir_tcdm_reader: directed vector bench with TCDM responder model    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_fir_tcdm_reader;

  localparam int unsigned FIFO_DEPTH = 4;

  typedef struct {
    logic [31:0] base;
    logic [15:0] len;
    logic [31:0] stride;
    bit          stall;
    int          ready_hold;
    bit          poke;
    logic [31:0] exp_last;
    bit          check_rate;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        start;
  logic [31:0] base;
  logic [15:0] len;
  logic [31:0] stride;
  logic        busy;
  logic        done;
  logic        req;
  logic        gnt;
  logic [31:0] add;
  logic        wen;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        ovalid;
  logic [31:0] odata;
  logic        oready;

  int n_tests = 0;
  int n_fail  = 0;

  bit          stall_mode = 1'b0;
  logic [31:0] gaddr[$];
  int          gcyc[$];
  logic [31:0] dq[$];
  int          done_cnt, req_cnt, busy_cnt, stab_err, first_pop_grants, tick;

  vec_t vecs[6];

  always #5 clk = ~clk;

  fir_tcdm_reader dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .clear_i        (clear),
    .start_i        (start),
    .base_addr_i    (base),
    .len_i          (len),
    .stride_i       (stride),
    .busy_o         (busy),
    .done_o         (done),
    .tcdm_req_o     (req),
    .tcdm_gnt_i     (gnt),
    .tcdm_add_o     (add),
    .tcdm_wen_o     (wen),
    .tcdm_be_o      (be),
    .tcdm_data_o    (wdata),
    .tcdm_r_data_i  (rdata),
    .tcdm_r_valid_i (rvalid),
    .out_valid_o    (ovalid),
    .out_data_o     (odata),
    .out_ready_i    (oready)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  function automatic logic [31:0] qget(input int i);
    return (i < dq.size()) ? dq[i] : 32'hDEAD_DEAD;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    gaddr.delete();
    gcyc.delete();
    dq.delete();
    done_cnt = 0;
    req_cnt = 0;
    busy_cnt = 0;
    stab_err = 0;
    first_pop_grants = -1;
  endtask

  // Monitor at negedge, then drive responder inputs just after the next posedge.
  initial begin
    logic        hs, prev_req, prev_gnt;
    logic [31:0] hs_addr, prev_add;
    hs = 1'b0; prev_req = 1'b0; prev_gnt = 1'b0; hs_addr = '0; prev_add = '0;
    tick = 0;
    gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    forever begin
      @(negedge clk);
      tick++;
      hs = 1'b0;
      if (rst_n) begin
        if (prev_req && !prev_gnt && !clear && (!req || add !== prev_add)) stab_err++;
        prev_req = req; prev_gnt = gnt; prev_add = add;
        if (req) req_cnt++;
        if (busy) busy_cnt++;
        if (ovalid && oready) begin
          if (first_pop_grants < 0) first_pop_grants = gaddr.size();
          dq.push_back(odata);
        end
        hs = req && gnt;
        if (hs) begin
          gaddr.push_back(add);
          gcyc.push_back(tick);
        end
        if (done) done_cnt++;
        hs_addr = add;
      end
      @(posedge clk);
      #1;
      rvalid = hs;
      rdata  = hs ? mem_fn(hs_addr) : 32'h0;
      gnt    = stall_mode ? ($urandom_range(0, 9) != 0) : 1'b1;
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    string       p;
    int          cyc, aerr, derr;
    logic [31:0] a;
    p = $sformatf("v%0d_", idx);
    clear_logs();
    stall_mode = v.stall;
    oready = (v.ready_hold == 0);
    base = v.base; len = v.len; stride = v.stride; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (done_cnt == 0 && cyc < 2000) begin
      if (cyc == v.ready_hold) oready = 1'b1;
      if (v.poke && cyc == 3) begin
        chk({p, "busy_at_poke"}, 32'(busy), 32'd1);
        start = 1'b1; base = 32'hBAD0; len = 16'd1; stride = 32'd0;
      end else begin
        start = 1'b0; base = v.base; len = v.len; stride = v.stride;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    aerr = 0; derr = 0; a = v.base;
    for (int i = 0; i < int'(v.len); i++) begin
      if (i >= gaddr.size() || gaddr[i] !== a) aerr++;
      if (qget(i) !== mem_fn(a)) derr++;
      a = a + v.stride;
    end
    chk({p, "done_count"}, 32'(done_cnt), 32'd1);
    chk({p, "grant_count"}, 32'(gaddr.size()), 32'(v.len));
    chk({p, "word_count"}, 32'(dq.size()), 32'(v.len));
    chk({p, "addr_seq_errs"}, 32'(aerr), 32'd0);
    chk({p, "data_seq_errs"}, 32'(derr), 32'd0);
    chk({p, "last_addr"}, (gaddr.size() > 0) ? gaddr[gaddr.size()-1] : 32'hDEAD_DEAD, v.exp_last);
    chk({p, "req_hold_errs"}, 32'(stab_err), 32'd0);
    chk({p, "busy_after"}, 32'(busy), 32'd0);
    if (v.check_rate)
      chk({p, "grant_span"}, (gcyc.size() > 0) ? 32'(gcyc[gcyc.size()-1] - gcyc[0]) : 32'hFFFF_FFFF,
          32'(v.len) - 32'd1);
    if (v.ready_hold > 0) begin
      n_tests++;
      if (first_pop_grants < 1 || first_pop_grants > int'(FIFO_DEPTH)) begin
        n_fail++;
        $display("FAIL %scredit: %0d grants before first pop, allowed 1..%0d", p, first_pop_grants, FIFO_DEPTH);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    vecs[0] = '{32'h0000_1000, 16'd4,  32'd4,          1'b0, 0,  1'b0, 32'h0000_100C, 1'b1};
    vecs[1] = '{32'h0000_0004, 16'd3,  32'hFFFF_FFFC,  1'b0, 0,  1'b0, 32'hFFFF_FFFC, 1'b1};
    vecs[2] = '{32'h0000_0100, 16'd16, 32'd4,          1'b1, 20, 1'b0, 32'h0000_013C, 1'b0};
    vecs[3] = '{32'h0000_5000, 16'd6,  32'd8,          1'b0, 0,  1'b1, 32'h0000_5028, 1'b1};
    vecs[4] = '{32'hFFFF_FFF8, 16'd3,  32'd8,          1'b0, 0,  1'b0, 32'h0000_0008, 1'b1};
    vecs[5] = '{32'h0000_0000, 16'd1,  32'd0,          1'b0, 0,  1'b0, 32'h0000_0000, 1'b1};

    rst_n = 1'b0; clear = 1'b0; start = 1'b0; base = '0; len = '0; stride = '0; oready = 1'b0;
    clear_logs();
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out_valid", 32'(ovalid), 32'd0);
    chk("rst_out_data", odata, 32'd0);
    chk("rst_add", add, 32'd0);
    chk("rst_wen", 32'(wen), 32'd1);
    chk("rst_be", 32'(be), 32'hF);
    chk("rst_wdata", wdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Zero-length transfer: done one cycle after start, no request, never busy.
    stall_mode = 1'b0;
    clear_logs();
    base = 32'h0000_7000; len = 16'd0; stride = 32'd4; start = 1'b1;
    @(negedge clk);
    chk("len0_done_same_cycle", 32'(done), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("len0_done_next_cycle", 32'(done), 32'd1);
    @(negedge clk);
    chk("len0_done_single", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    chk("len0_req_cycles", 32'(req_cnt), 32'd0);
    chk("len0_busy_cycles", 32'(busy_cnt), 32'd0);
    chk("len0_done_count", 32'(done_cnt), 32'd1);

    // Clear one cycle after a grant, then a fresh short transfer.
    @(posedge clk); #1;
    clear_logs();
    oready = 1'b1;
    base = 32'h0000_3000; len = 16'd8; stride = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (gaddr.size() < 2 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("clr_grants_seen", 32'(gaddr.size()), 32'd2);
    clear = 1'b1;
    @(negedge clk);
    chk("clr_req_dropped", 32'(req), 32'd0);
    @(posedge clk); #1;
    clear = 1'b0;
    dq.delete();
    @(negedge clk);
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_out_valid", 32'(ovalid), 32'd0);
    repeat (4) @(negedge clk);
    chk("clr_no_words", 32'(dq.size()), 32'd0);
    chk("clr_no_done", 32'(done_cnt), 32'd0);
    @(posedge clk); #1;
    clear_logs();
    base = 32'h0000_2000; len = 16'd2; stride = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (done_cnt == 0 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("clr_new_done", 32'(done_cnt), 32'd1);
    chk("clr_new_words", 32'(dq.size()), 32'd2);
    chk("clr_new_word0", qget(0), mem_fn(32'h0000_2000));
    chk("clr_new_word1", qget(1), mem_fn(32'h0000_2004));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
